p_mc: RTL

Parametrised multi-cycle successor to the single-cycle 8-bit core. It fetches instructions over a request/valid instruction-memory handshake, so memory may stall for any number of cycles. It executes a four-opcode ISA (ADD, ADDI, SUB, JMP) on an internal register file, with generic data, PC and register-address widths. A sticky signed-overflow flag, a retire strobe and a debug register read port are provided for bring-up and verification.

---
 rtl/p_mc.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/p_mc.sv
// ---------------------------------------------------------------------------
// p_mc -- parametrised multi-cycle core with a handshaked instruction fetch.
//
// Every instruction takes a FETCH phase and then one EXEC cycle. FETCH holds
// imem_req high and waits for imem_valid, however many cycles that takes.
// EXEC applies the register write or the PC update and pulses retire.
// The ISA has four opcodes (ADD, ADDI, SUB, JMP) that work on an internal
// register file. Signed overflow on ADD/ADDI/SUB sets a sticky flag.
//
// Parameters
//   DATA_W  register / ALU width (>= 2)
//   PC_W    program counter width (>= 2)
//   RA_W    register address width; NREGS = 2**RA_W, IW = 2 + 2*RA_W
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   imem_req    fetch request (high in FETCH)
//   imem_addr   fetch address, always equal to pc
//   imem_valid  instruction word valid; only sampled in FETCH
//   imem_rdata  instruction word {op[1:0], rd, rs}
//   retire      one-cycle pulse in the EXEC cycle of each instruction
//   retire_pc   address of the retiring instruction, valid with retire
//   ovf         sticky signed-overflow flag
//   pc          current program counter
//   dbg_raddr   debug register select
//   dbg_rdata   combinational read of reg[dbg_raddr]
// ---------------------------------------------------------------------------
module p_mc #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int RA_W   = 3,
  localparam int IW    = 2 + 2 * RA_W,
  localparam int NREGS = 1 << RA_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_valid,
  input  logic [IW-1:0]     imem_rdata,
  output logic              retire,
  output logic [PC_W-1:0]   retire_pc,
  output logic              ovf,
  output logic [PC_W-1:0]   pc,
  input  logic [RA_W-1:0]   dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  typedef enum logic {
    FETCH,
    EXEC
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_ADDI = 2'b01,
    OP_SUB  = 2'b10,
    OP_JMP  = 2'b11
  } op_t;

  state_t            state;
  logic [IW-1:0]     ir;
  logic [DATA_W-1:0] regs [NREGS];

  // Instruction decode from the latched instruction register.
  op_t             op;
  logic [RA_W-1:0] rd;
  logic [RA_W-1:0] rs;

  assign op = op_t'(ir[IW-1:IW-2]);
  assign rd = ir[2*RA_W-1:RA_W];
  assign rs = ir[RA_W-1:0];

  // The size casts of signed values sign-extend (or truncate when the target
  // is narrower), which is exactly the behaviour the immediate and jump
  // offset need.
  logic [DATA_W-1:0] imm;
  logic [PC_W-1:0]   jmp_off;
  logic [PC_W-1:0]   pc_inc;

  assign imm     = DATA_W'($signed(rs));
  assign jmp_off = PC_W'($signed(ir[2*RA_W-1:0]));
  assign pc_inc  = pc + PC_W'(1);

  // ALU. Operands are read before the EXEC edge, so rd == rs naturally uses
  // the old value for both operands.
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    op_a    = regs[rd];
    op_b    = regs[rs];
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (op)
      OP_ADD, OP_ADDI: begin
        if (op == OP_ADDI) op_b = imm;
        alu_res = op_a + op_b;
        alu_ovf = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != op_a[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = op_a - op_b;
        alu_ovf = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != op_a[DATA_W-1]);
      end
      default: ;  // OP_JMP: no data result
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= '0;
      ovf       <= 1'b0;
      retire_pc <= '0;
      ir        <= '0;
      // NOTE: the register file is architecturally zero after reset, so it is
      // reset explicitly; it is small enough to be built from flops.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_valid) begin
            ir        <= imem_rdata;
            retire_pc <= pc;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (op == OP_JMP) begin
            pc <= pc_inc + jmp_off;
          end else begin
            regs[rd] <= alu_res;
            pc       <= pc_inc;
            if (alu_ovf) ovf <= 1'b1;
          end
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // A reset arriving in EXEC cancels the instruction, so retire is masked by
  // reset: the instruction never completes and must not be reported.
  assign retire    = (state == EXEC) && !reset;
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign dbg_rdata = regs[dbg_raddr];

endmodule
